// File: rtl/hedios_tx_arbiter.sv
// Round-robin arbiter sharing the HEDIOS TX packet queue between NUM_REQ producers.
// One packet per IDLE -> PUSH -> SETTLE pass; requester 0 may optionally override the rotation.
module hedios_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter bit PRIO0   = 1'b0,
    localparam int GW     = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*8-1:0]  req_command,
    input  logic [NUM_REQ*32-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic                  queue_full,
    output logic                  push_packet,
    output logic [7:0]            packet_command,
    output logic [31:0]           packet_data,
    output logic [GW-1:0]         grant_id,
    output logic                  busy,
    output logic [15:0]           sent_count
);

    typedef enum logic [1:0] {IDLE, PUSH, SETTLE} state_t;

    state_t               state_reg, state_next;
    logic [GW-1:0]        rr_ptr_reg, rr_ptr_next;
    logic [GW-1:0]        grant_id_reg, grant_id_next;
    logic [NUM_REQ-1:0]   req_ready_reg, req_ready_next;
    logic                 push_reg, push_next;
    logic [7:0]           cmd_reg, cmd_next;
    logic [31:0]          data_reg, data_next;
    logic                 busy_reg, busy_next;
    logic [15:0]          count_reg, count_next;

    logic [7:0]           slot_cmd  [NUM_REQ];
    logic [31:0]          slot_data [NUM_REQ];
    logic [GW-1:0]        win;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slot
            assign slot_cmd[gi]  = req_command[gi*8 +: 8];
            assign slot_data[gi] = req_data[gi*32 +: 32];
        end
    endgenerate

    // Scan from the farthest offset back to rr_ptr so the nearest valid slot wins last.
    always_comb begin
        int            idx;
        logic [GW-1:0] idx_w;
        win   = '0;
        idx   = 0;
        idx_w = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx   = (int'(rr_ptr_reg) + k) % NUM_REQ;
            idx_w = GW'(idx);
            if (req_valid[idx_w]) begin
                win = idx_w;
            end
        end
        if (PRIO0 && req_valid[0]) begin
            win = '0;
        end
    end

    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        grant_id_next  = grant_id_reg;
        req_ready_next = '0;
        push_next      = 1'b0;
        cmd_next       = cmd_reg;
        data_next      = data_reg;
        count_next     = count_reg;
        case (state_reg)
            IDLE: begin
                if ((|req_valid) && !queue_full) begin
                    cmd_next       = slot_cmd[win];
                    data_next      = slot_data[win];
                    grant_id_next  = win;
                    req_ready_next = NUM_REQ'(1) << win;
                    push_next      = 1'b1;
                    rr_ptr_next    = GW'((int'(win) + 1) % NUM_REQ);
                    state_next     = PUSH;
                end
            end
            PUSH: begin
                count_next = count_reg + 16'd1;
                state_next = SETTLE;
            end
            // Dead cycle: lets queue_full reflect the push before the next grant.
            SETTLE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            grant_id_reg  <= '0;
            req_ready_reg <= '0;
            push_reg      <= 1'b0;
            cmd_reg       <= '0;
            data_reg      <= '0;
            busy_reg      <= 1'b0;
            count_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            grant_id_reg  <= grant_id_next;
            req_ready_reg <= req_ready_next;
            push_reg      <= push_next;
            cmd_reg       <= cmd_next;
            data_reg      <= data_next;
            busy_reg      <= busy_next;
            count_reg     <= count_next;
        end
    end

    assign req_ready      = req_ready_reg;
    assign push_packet    = push_reg;
    assign packet_command = cmd_reg;
    assign packet_data    = data_reg;
    assign grant_id       = grant_id_reg;
    assign busy           = busy_reg;
    assign sent_count     = count_reg;

endmodule

// File: tb/tb_hedios_tx_arbiter.sv
// Bench for hedios_tx_arbiter: table-driven grants checked through a push scoreboard,
// plus hand sequences for backpressure, fixed priority, counter wrap and reset during a push.
module tb_hedios_tx_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [3:0]   valid;
    logic [3:0]   p_valid;
    logic [31:0]  cmd_bus;
    logic [127:0] data_bus;
    logic         queue_full;
    logic         p_full;

    logic [3:0]   req_ready, p_ready;
    logic         push_packet, p_push;
    logic [7:0]   packet_command, p_cmd;
    logic [31:0]  packet_data, p_data;
    logic [1:0]   grant_id, p_grant;
    logic         busy, p_busy;
    logic [15:0]  sent_count, p_count;

    always #5 clk = ~clk;

    hedios_tx_arbiter #(.NUM_REQ(4), .PRIO0(1'b0)) dut (
        .clk(clk), .rst(rst), .req_valid(valid), .req_command(cmd_bus), .req_data(data_bus),
        .req_ready(req_ready), .queue_full(queue_full), .push_packet(push_packet),
        .packet_command(packet_command), .packet_data(packet_data), .grant_id(grant_id),
        .busy(busy), .sent_count(sent_count)
    );

    hedios_tx_arbiter #(.NUM_REQ(4), .PRIO0(1'b1)) dut_p (
        .clk(clk), .rst(rst), .req_valid(p_valid), .req_command(cmd_bus), .req_data(data_bus),
        .req_ready(p_ready), .queue_full(p_full), .push_packet(p_push),
        .packet_command(p_cmd), .packet_data(p_data), .grant_id(p_grant),
        .busy(p_busy), .sent_count(p_count)
    );

    typedef struct {
        logic [3:0]  mask;
        logic        full;
        logic        grant;
        int          win;
        logic [7:0]  cmd_base;
        logic [31:0] data_base;
        int          gap;
    } vec_t;

    typedef struct {
        int          id;
        logic [7:0]  cmd;
        logic [31:0] data;
        int          gap;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    vec_t        vecs[15];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cycle = 0;
    int          last_push = 0;
    bit          mon_en = 1'b0;
    logic [15:0] exp_count = 16'd0;
    int          exp_grant = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic set_payload(input logic [7:0] cb, input logic [31:0] db);
        for (int i = 0; i < 4; i++) begin
            cmd_bus[i*8 +: 8]   = cb + 8'(i);
            data_bus[i*32 +: 32] = db ^ 32'(i);
        end
    endtask

    // Scoreboard side: every push must match the oldest queued expectation.
    always @(negedge clk) begin
        cycle++;
        if (mon_en) begin
            if (push_packet === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_push: got push cmd %h, required no push", packet_command);
                end else begin
                    mon_e = sb.pop_front();
                    check("push_cmd", 64'(packet_command), 64'(mon_e.cmd));
                    check("push_data", 64'(packet_data), 64'(mon_e.data));
                    check("push_ready", 64'(req_ready), 64'(4'b0001 << mon_e.id));
                    check("push_grant", 64'(grant_id), 64'(mon_e.id));
                    if (mon_e.gap != 0)
                        check("push_gap", 64'(cycle - last_push), 64'(mon_e.gap));
                end
                last_push = cycle;
            end else begin
                check("ready_without_push", 64'(req_ready), 64'd0);
            end
        end
    end

    task automatic run_vec(input vec_t v);
        exp_t e;
        logic b1, b2, b3;
        set_payload(v.cmd_base, v.data_base);
        valid      = v.mask;
        queue_full = v.full;
        if (v.grant) begin
            e.id   = v.win;
            e.cmd  = v.cmd_base + 8'(v.win);
            e.data = v.data_base ^ 32'(v.win);
            e.gap  = v.gap;
            sb.push_back(e);
            exp_count = exp_count + 16'd1;
            exp_grant = v.win;
        end
        @(negedge clk);
        b1 = busy;
        check("grant_id", 64'(grant_id), 64'(exp_grant));
        @(negedge clk);
        b2 = busy;
        @(negedge clk);
        b3 = busy;
        check("busy_profile", 64'({b1, b2, b3}), v.grant ? 64'd6 : 64'd0);
        check("sent_count", 64'(sent_count), 64'(exp_count));
    endtask

    initial begin
        int   cnt;
        bit   got;
        exp_t e;

        vecs[0]  = '{4'b1111, 1'b0, 1'b1, 0, 8'h10, 32'h1000_1000, 0};
        vecs[1]  = '{4'b1111, 1'b0, 1'b1, 1, 8'h20, 32'h2000_2000, 3};
        vecs[2]  = '{4'b1111, 1'b0, 1'b1, 2, 8'h30, 32'h3000_3000, 3};
        vecs[3]  = '{4'b1111, 1'b0, 1'b1, 3, 8'h40, 32'h4000_4000, 3};
        vecs[4]  = '{4'b1111, 1'b0, 1'b1, 0, 8'h50, 32'h5000_5000, 3};
        vecs[5]  = '{4'b0100, 1'b0, 1'b1, 2, 8'hA3, 32'hDEAD_BEED, 0};
        vecs[6]  = '{4'b0101, 1'b0, 1'b1, 0, 8'h60, 32'h6000_6000, 0};
        vecs[7]  = '{4'b0101, 1'b0, 1'b1, 2, 8'h70, 32'h7000_7000, 0};
        vecs[8]  = '{4'b1000, 1'b0, 1'b1, 3, 8'h80, 32'h8000_8000, 0};
        vecs[9]  = '{4'b0000, 1'b0, 1'b0, 0, 8'h90, 32'h9000_9000, 0};
        vecs[10] = '{4'b1010, 1'b1, 1'b0, 0, 8'hA0, 32'hA000_A000, 0};
        vecs[11] = '{4'b1010, 1'b0, 1'b1, 1, 8'hB0, 32'hB000_B000, 0};
        vecs[12] = '{4'b0011, 1'b0, 1'b1, 0, 8'hC0, 32'hC000_C000, 0};
        vecs[13] = '{4'b0011, 1'b0, 1'b1, 1, 8'hD0, 32'hD000_D000, 0};
        vecs[14] = '{4'b1001, 1'b0, 1'b1, 3, 8'hE0, 32'hE000_E000, 0};

        // Reset held with every requester asserting.
        rst        = 1'b0;
        valid      = 4'b1111;
        p_valid    = 4'b0000;
        queue_full = 1'b0;
        p_full     = 1'b0;
        set_payload(8'h01, 32'h0101_0101);
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs",
                  {push_packet, req_ready, packet_command, packet_data, grant_id, busy, sent_count},
                  64'd0);
        end
        rst    = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < 15; i++) run_vec(vecs[i]);

        // Backpressure: full for 20 cycles, then release.
        set_payload(8'h60, 32'h6060_0000);
        valid      = 4'b0010;
        queue_full = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (push_packet !== 1'b0 || busy !== 1'b0) cnt++;
        end
        check("full_no_push", 64'(cnt), 64'd0);
        queue_full = 1'b0;
        e = '{1, 8'h61, 32'h6060_0001, 0};
        sb.push_back(e);
        exp_count = exp_count + 16'd1;
        exp_grant = 1;
        @(negedge clk);
        check("full_release_push", 64'(push_packet), 64'd1);
        @(negedge clk);
        valid = 4'b0000;
        @(negedge clk);
        check("full_sent_count", 64'(sent_count), 64'(exp_count));

        // Fixed priority on the PRIO0 instance.
        set_payload(8'h70, 32'h1234_5678);
        p_valid = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            for (int c = 0; c < 4 && !got; c++) begin
                @(negedge clk);
                if (p_push === 1'b1) got = 1'b1;
            end
            check("prio_push_seen", 64'(got), 64'd1);
            check("prio_grant", 64'(p_grant), 64'd0);
            check("prio_ready", 64'(p_ready), 64'd1);
            check("prio_cmd", 64'(p_cmd), 64'h70);
        end
        @(negedge clk);
        p_valid = 4'b1000;
        got = 1'b0;
        for (int c = 0; c < 3 && !got; c++) begin
            @(negedge clk);
            if (p_push === 1'b1) got = 1'b1;
        end
        check("prio_drop_push_seen", 64'(got), 64'd1);
        check("prio_drop_grant", 64'(p_grant), 64'd3);
        check("prio_drop_ready", 64'(p_ready), 64'd8);
        check("prio_drop_data", 64'(p_data), 64'h1234_567B);
        @(negedge clk);
        p_valid = 4'b0000;
        check("prio_sent_count", 64'(p_count), 64'd5);

        // Counter wrap from 0xFFFF.
        force dut.count_reg = 16'hFFFF;
        repeat (2) @(negedge clk);
        release dut.count_reg;
        exp_count = 16'hFFFF;
        run_vec('{4'b0001, 1'b0, 1'b1, 0, 8'hF0, 32'hF0F0_0000, 0});

        // Reset during PUSH: the packet is seen, then dropped state-wise.
        set_payload(8'hC0, 32'hC0C0_0000);
        valid = 4'b0010;
        e = '{1, 8'hC1, 32'hC0C0_0001, 0};
        sb.push_back(e);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_push_outputs",
              {push_packet, req_ready, packet_command, packet_data, grant_id, busy, sent_count},
              64'd0);
        check("rst_push_prio_count", 64'(p_count), 64'd0);
        rst       = 1'b1;
        exp_count = 16'd0;
        exp_grant = 0;
        run_vec('{4'b0110, 1'b0, 1'b1, 1, 8'hD0, 32'hD0D0_0000, 0});
        valid = 4'b0000;
        repeat (2) @(negedge clk);

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
